// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encoding
// and the mapping of mux levels onto pipeline stages.
// Optional feature macro used by the shifter files: SHIFT_WORD_OP_EN.
package shift_pkg;

    localparam int SHIFT_OP_W = 3;

    // Codes 5..7 are not listed; the datapath passes such operands through unshifted.
    typedef enum logic [SHIFT_OP_W-1:0] {
        SLL = 3'd0,
        SRL = 3'd1,
        SRA = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4
    } shift_op_t;

    // First mux level owned by stage s (inclusive).
    function automatic int stage_lo(input int s, input int stages, input int amt_w);
        return (s * amt_w) / stages;
    endfunction

    // Last mux level owned by stage s (exclusive); the final stage takes the remainder.
    function automatic int stage_hi(input int s, input int stages, input int amt_w);
        int hi;
        if (s == stages - 1) begin
            hi = amt_w;
        end else begin
            hi = ((s + 1) * amt_w) / stages;
        end
        return hi;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline slice of the barrel shifter. Applies mux levels
// [LVL_LO, LVL_HI) to the incoming operand and registers the result
// together with valid, amount, op, sign and tag.
// With SHIFT_WORD_OP_EN defined, a word flag travels with the op and
// switches the levels to 32-bit operation on the low half.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int TAG_W  = 4,
    parameter int AMT_W  = 6,
    parameter int LVL_LO = 0,
    parameter int LVL_HI = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  up_valid_i,
    input  logic [WIDTH-1:0]      up_data_i,
    input  logic [AMT_W-1:0]      up_amt_i,
    input  logic [SHIFT_OP_W-1:0] up_op_i,
    input  logic                  up_sign_i,
    input  logic [TAG_W-1:0]      up_tag_i,
`ifdef SHIFT_WORD_OP_EN
    input  logic                  up_word_i,
    output logic                  dn_word_o,
`endif
    output logic                  dn_valid_o,
    output logic [WIDTH-1:0]      dn_data_o,
    output logic [AMT_W-1:0]      dn_amt_o,
    output logic [SHIFT_OP_W-1:0] dn_op_o,
    output logic                  dn_sign_o,
    output logic [TAG_W-1:0]      dn_tag_o
);

    logic                  valid_q;
    logic [WIDTH-1:0]      data_q;
    logic [WIDTH-1:0]      data_d;
    logic [AMT_W-1:0]      amt_q;
    logic [SHIFT_OP_W-1:0] op_q;
    logic                  sign_q;
    logic [TAG_W-1:0]      tag_q;
`ifdef SHIFT_WORD_OP_EN
    logic                  word_q;
`endif

    // Full-width shift/rotate by a constant k; sign supplies the SRA fill.
    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0]      d,
                                                     input logic [SHIFT_OP_W-1:0] op,
                                                     input logic                  sign,
                                                     input int                    k);
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] r;
        fill = sign ? ~({WIDTH{1'b1}} >> k) : '0;
        case (op)
            SLL:     r = d << k;
            SRL:     r = d >> k;
            SRA:     r = (d >> k) | fill;
            ROL:     r = (d << k) | (d >> (WIDTH - k));
            ROR:     r = (d >> k) | (d << (WIDTH - k));
            default: r = d;
        endcase
        return r;
    endfunction

`ifdef SHIFT_WORD_OP_EN
    // 32-bit variant on the low half; the upper half is rebuilt by sign
    // extension at the pipeline output, so it is simply carried here.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0]      d,
                                                    input logic [SHIFT_OP_W-1:0] op,
                                                    input logic                  sign,
                                                    input int                    k);
        logic [31:0] w;
        logic [31:0] fill;
        logic [31:0] r;
        w    = d[31:0];
        fill = sign ? ~(32'hFFFF_FFFF >> k) : '0;
        case (op)
            SLL:     r = w << k;
            SRL:     r = w >> k;
            SRA:     r = (w >> k) | fill;
            ROL:     r = (w << k) | (w >> (32 - k));
            ROR:     r = (w >> k) | (w << (32 - k));
            default: r = w;
        endcase
        return {d[WIDTH-1:32], r};
    endfunction
`endif

    // Mux levels owned by this slice: level i shifts by 2^i when amt[i] is set.
    always_comb begin
        data_d = up_data_i;
        for (int i = LVL_LO; i < LVL_HI; i++) begin
            if (up_amt_i[i]) begin
`ifdef SHIFT_WORD_OP_EN
                if (up_word_i) begin
                    data_d = shift_word(data_d, up_op_i, up_sign_i, 1 << i);
                end else begin
                    data_d = shift_level(data_d, up_op_i, up_sign_i, 1 << i);
                end
`else
                data_d = shift_level(data_d, up_op_i, up_sign_i, 1 << i);
`endif
            end
        end
    end

    // Slice register: loads when the slice advances, payload only for valid beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            op_q    <= '0;
            sign_q  <= 1'b0;
            tag_q   <= '0;
`ifdef SHIFT_WORD_OP_EN
            word_q  <= 1'b0;
`endif
        end else if (load_i) begin
            valid_q <= up_valid_i;
            if (up_valid_i) begin
                data_q <= data_d;
                amt_q  <= up_amt_i;
                op_q   <= up_op_i;
                sign_q <= up_sign_i;
                tag_q  <= up_tag_i;
`ifdef SHIFT_WORD_OP_EN
                word_q <= up_word_i;
`endif
            end
        end
    end

    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;
    assign dn_amt_o   = amt_q;
    assign dn_op_o    = op_q;
    assign dn_sign_o  = sign_q;
    assign dn_tag_o   = tag_q;
`ifdef SHIFT_WORD_OP_EN
    assign dn_word_o  = word_q;
`endif

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with a pass-through tag.
// STAGES slices of shift_stage split the log2(WIDTH) mux levels.
// Optional feature macro: SHIFT_WORD_OP_EN adds in_word for RV64 *W ops
// (32-bit operation, result sign-extended; WIDTH must be 64).
//
// Handshake: a beat moves on a rising edge where valid && ready are both
// high. in_ready/out_ready flow backwards combinationally through the stall
// chain; valid and payload flow forwards only through registers, so in_*
// never reaches out_* in the same cycle, and a stalled output holds steady.
module pipe_shifter
    import shift_pkg::*;
#(
    parameter  int WIDTH  = 64,
    parameter  int STAGES = 2,
    parameter  int TAG_W  = 4,
    localparam int AMT_W  = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [AMT_W-1:0]      in_amt,
    input  logic [SHIFT_OP_W-1:0] in_op,
    input  logic [TAG_W-1:0]      in_tag,
`ifdef SHIFT_WORD_OP_EN
    input  logic                  in_word,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [TAG_W-1:0]      out_tag
);

    if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("pipe_shifter: WIDTH must be a power of two and at least 8");
    end
    if (STAGES < 1 || STAGES > AMT_W) begin : g_bad_stages
        $error("pipe_shifter: STAGES must lie in 1..log2(WIDTH)");
    end
`ifdef SHIFT_WORD_OP_EN
    if (WIDTH != 64) begin : g_bad_word
        $error("pipe_shifter: word operations need WIDTH == 64");
    end
`endif

    // Index s is the input of slice s; index STAGES is the pipeline output.
    logic [STAGES:0]       v_c;
    logic [STAGES:0]       adv_c;
    logic [STAGES:0]       sign_c;
    logic [WIDTH-1:0]      data_c [STAGES+1];
    logic [AMT_W-1:0]      amt_c  [STAGES+1];
    logic [SHIFT_OP_W-1:0] op_c   [STAGES+1];
    logic [TAG_W-1:0]      tag_c  [STAGES+1];
`ifdef SHIFT_WORD_OP_EN
    logic [STAGES:0]       word_c;
`endif
    logic                  unused_tail;

    // Operand preparation: word ops mask the amount to 5 bits and take the sign from bit 31.
    always_comb begin
        v_c[0]    = in_valid;
        data_c[0] = in_data;
        amt_c[0]  = in_amt;
        op_c[0]   = in_op;
        tag_c[0]  = in_tag;
        sign_c[0] = in_data[WIDTH-1];
`ifdef SHIFT_WORD_OP_EN
        word_c[0] = in_word;
        if (in_word) begin
            amt_c[0]  = in_amt & AMT_W'(31);
            sign_c[0] = in_data[31];
        end
`endif
    end

    // Stall chain: a slice advances when its register is empty or the next one advances.
    always_comb begin
        adv_c         = '0;
        adv_c[STAGES] = out_ready;
        for (int s = STAGES - 1; s >= 0; s--) begin
            adv_c[s] = !v_c[s+1] || adv_c[s+1];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        shift_stage #(
            .WIDTH  (WIDTH),
            .TAG_W  (TAG_W),
            .AMT_W  (AMT_W),
            .LVL_LO (stage_lo(s, STAGES, AMT_W)),
            .LVL_HI (stage_hi(s, STAGES, AMT_W))
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .load_i     (adv_c[s]),
            .up_valid_i (v_c[s]),
            .up_data_i  (data_c[s]),
            .up_amt_i   (amt_c[s]),
            .up_op_i    (op_c[s]),
            .up_sign_i  (sign_c[s]),
            .up_tag_i   (tag_c[s]),
`ifdef SHIFT_WORD_OP_EN
            .up_word_i  (word_c[s]),
            .dn_word_o  (word_c[s+1]),
`endif
            .dn_valid_o (v_c[s+1]),
            .dn_data_o  (data_c[s+1]),
            .dn_amt_o   (amt_c[s+1]),
            .dn_op_o    (op_c[s+1]),
            .dn_sign_o  (sign_c[s+1]),
            .dn_tag_o   (tag_c[s+1])
        );
    end

    // Output stage: word results are rebuilt by sign extension from bit 31.
    always_comb begin
        out_data = data_c[STAGES];
`ifdef SHIFT_WORD_OP_EN
        if (word_c[STAGES] && op_c[STAGES] <= SHIFT_OP_W'(ROR)) begin
            out_data = {{(WIDTH-32){data_c[STAGES][31]}}, data_c[STAGES][31:0]};
        end
`endif
    end

    assign out_valid = v_c[STAGES];
    assign out_tag   = tag_c[STAGES];
    // Reported ready while reset is held so upstream never sees a stall from a flushing pipe.
    assign in_ready  = adv_c[0] || !rst_n;

    // Amount, sign and op are no longer needed once the last level has been applied.
    assign unused_tail = ^{amt_c[STAGES], sign_c[STAGES], op_c[STAGES]};

endmodule

// File: tb/tb_pipe_shifter.sv
// Self-checking bench for pipe_shifter (WIDTH=64, STAGES=2, TAG_W=4).
// Define SHIFT_WORD_OP_EN for both bench and RTL to exercise word ops.
module tb_pipe_shifter;

  localparam int W  = 64;
  localparam int AW = 6;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [AW-1:0] in_amt;
  logic [2:0]    in_op;
  logic [TW-1:0] in_tag;
  logic          in_word;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;

  int n_vec = 0;
  int n_err = 0;
  logic [TW+W-1:0] exp_q[$];

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1);
  end

  pipe_shifter #(
    .WIDTH  (W),
    .STAGES (2),
    .TAG_W  (TW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .in_tag    (in_tag),
`ifdef SHIFT_WORD_OP_EN
    .in_word   (in_word),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  // Reference model straight from the operation definitions.
  function automatic logic [W-1:0] ref_shift(input logic [2:0] op, input logic [W-1:0] d,
                                             input int a, input logic word);
    logic [W-1:0] r;
    logic [31:0]  w;
    logic [31:0]  rw;
    int           b;
    r = d;
    if (word && op <= 3'd4) begin
      w = d[31:0];
      b = a % 32;
      case (op)
        3'd0:    rw = w << b;
        3'd1:    rw = w >> b;
        3'd2:    rw = 32'($signed(w) >>> b);
        3'd3:    rw = (w << b) | (w >> (32 - b));
        default: rw = (w >> b) | (w << (32 - b));
      endcase
      r = {{32{rw[31]}}, rw};
    end else begin
      case (op)
        3'd0:    r = d << a;
        3'd1:    r = d >> a;
        3'd2:    r = W'($signed(d) >>> a);
        3'd3:    r = (d << a) | (d >> (W - a));
        3'd4:    r = (d >> a) | (d << (W - a));
        default: r = d;
      endcase
    end
    return r;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [W-1:0] d, input logic [AW-1:0] a,
                           input logic [TW-1:0] t, input logic w);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_amt   = a;
    in_tag   = t;
    in_word  = w;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Sends one request into an empty pipe and waits a bounded time for its result.
  task automatic send_one(input logic [2:0] op, input logic [W-1:0] d, input logic [AW-1:0] a,
                          input logic [TW-1:0] t, input logic w,
                          output logic [W-1:0] rd, output logic [TW-1:0] rt, output logic ok);
    ok = 1'b0;
    rd = '0;
    rt = '0;
    out_ready = 1'b1;
    drive_req(op, d, a, t, w);
    tick();
    idle();
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (out_valid) begin
        rd = out_data;
        rt = out_tag;
        ok = 1'b1;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_held: got %b want 1", in_ready); end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++;
    if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_vec++;
    if (out_tag !== '0) begin n_err++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_latency();
    int   lat;
    logic got;
    out_ready = 1'b1;
    drive_req(3'd2, 64'h8000_0000_0000_0000, 6'd63, 4'd5, 1'b0);
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL lat_accept: in_ready %b want 1", in_ready); end
    tick();
    idle();
    lat = 1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
      end else begin
        lat++;
        tick();
      end
    end
    n_vec++;
    if (!got || lat != 2) begin n_err++; $display("FAIL lat_cycles: got %0d (seen %b) want 2", lat, got); end
    n_vec++;
    if (out_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL lat_data: got %h want ffffffffffffffff", out_data); end
    n_vec++;
    if (out_tag !== 4'd5) begin n_err++; $display("FAIL lat_tag: got %0d want 5", out_tag); end
    tick();
  endtask

  task automatic test_back_to_back();
    int            ocyc[3] = '{-1, -1, -1};
    logic [W-1:0]  odat[3] = '{64'h0, 64'h0, 64'h0};
    logic [TW-1:0] otag[3] = '{4'h0, 4'h0, 4'h0};
    logic [W-1:0]  expd[3] = '{64'h1, 64'h8000_0000_0000_0000, 64'h8};
    int            nout = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0:       drive_req(3'd1, 64'h8000_0000_0000_0000, 6'd63, 4'd1, 1'b0);
        1:       drive_req(3'd4, 64'h1, 6'd1, 4'd2, 1'b0);
        2:       drive_req(3'd3, 64'h8000_0000_0000_0000, 6'd4, 4'd3, 1'b0);
        default: idle();
      endcase
      @(negedge clk);
      if (c < 3) begin
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_accept%0d: in_ready %b want 1", c, in_ready); end
      end
      if (out_valid) begin
        if (nout < 3) begin
          ocyc[nout] = c;
          odat[nout] = out_data;
          otag[nout] = out_tag;
        end
        nout++;
      end
      tick();
    end
    n_vec++;
    if (nout != 3) begin n_err++; $display("FAIL b2b_count: got %0d results want 3", nout); end
    for (int j = 0; j < 3; j++) begin
      n_vec++;
      if (ocyc[j] != j + 2 || odat[j] !== expd[j] || otag[j] !== 4'(j + 1)) begin
        n_err++;
        $display("FAIL b2b_result%0d: got cyc %0d data %h tag %0d want cyc %0d data %h tag %0d",
                 j, ocyc[j], odat[j], otag[j], j + 2, expd[j], j + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0]    ops[4];
    logic [W-1:0]  dat[4];
    logic [AW-1:0] amt[4];
    logic [W-1:0]  expd[4];
    logic [W-1:0]  held = '0;
    logic          have_held = 1'b0;
    int            idx = 0;
    int            nout = 0;
    for (int i = 0; i < 4; i++) begin
      ops[i]  = 3'($urandom_range(0, 4));
      dat[i]  = {$urandom, $urandom};
      amt[i]  = AW'($urandom_range(1, 63));
      expd[i] = ref_shift(ops[i], dat[i], int'(amt[i]), 1'b0);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 4) drive_req(ops[idx], dat[idx], amt[idx], 4'(8 + idx), 1'b0);
      else idle();
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid) begin
        if (!have_held) begin
          held = out_data;
          have_held = 1'b1;
        end else begin
          n_vec++;
          if (out_data !== held) begin n_err++; $display("FAIL bp_hold: got %h want %h", out_data, held); end
        end
      end
      tick();
    end
    n_vec++;
    if (idx != 2) begin n_err++; $display("FAIL bp_accepted: got %0d want 2", idx); end
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== expd[0]) begin
      n_err++;
      $display("FAIL bp_head: got valid %b data %h want 1 %h", out_valid, out_data, expd[0]);
    end
    tick();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (idx < 4) drive_req(ops[idx], dat[idx], amt[idx], 4'(8 + idx), 1'b0);
      else idle();
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_vec++;
        if (nout >= 4) begin
          n_err++;
          $display("FAIL bp_extra: unexpected result %h tag %0d", out_data, out_tag);
        end else if ({out_tag, out_data} !== {4'(8 + nout), expd[nout]}) begin
          n_err++;
          $display("FAIL bp_result%0d: got %h tag %0d want %h tag %0d",
                   nout, out_data, out_tag, expd[nout], 8 + nout);
        end
        nout++;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    idle();
    n_vec++;
    if (nout != 4 || idx != 4) begin n_err++; $display("FAIL bp_total: got %0d out %0d in want 4 4", nout, idx); end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    out_ready = 1'b0;
    drive_req(3'd0, 64'hDEAD_BEEF_0000_0001, 6'd1, 4'd1, 1'b0);
    tick();
    drive_req(3'd1, 64'hCAFE_F00D_0000_0002, 6'd2, 4'd2, 1'b0);
    tick();
    idle();
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rm_prefill: got valid %b ready %b want 1 0", out_valid, in_ready);
    end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
    n_vec++;
    if (out_data !== '0 || out_tag !== '0) begin
      n_err++;
      $display("FAIL rm_out_cleared: got %h tag %0d want 0 0", out_data, out_tag);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
      tick();
    end
    n_vec++;
    if (stale != 0) begin n_err++; $display("FAIL rm_stale: got %0d results want 0", stale); end
  endtask

  task automatic test_boundaries();
    logic [W-1:0]  rd;
    logic [TW-1:0] rt;
    logic          ok;
    logic [W-1:0]  pat = 64'h1234_5678_9ABC_DEF0;
    for (int i = 0; i < 5; i++) begin
      send_one(3'(i), pat, 6'd0, 4'(i), 1'b0, rd, rt, ok);
      n_vec++;
      if (!ok || rd !== pat || rt !== 4'(i)) begin
        n_err++;
        $display("FAIL bnd_amt0_op%0d: got %h tag %0d (seen %b) want %h tag %0d", i, rd, rt, ok, pat, i);
      end
    end
    for (int i = 5; i < 8; i++) begin
      send_one(3'(i), pat, 6'd17, 4'hA, 1'b0, rd, rt, ok);
      n_vec++;
      if (!ok || rd !== pat || rt !== 4'hA) begin
        n_err++;
        $display("FAIL bnd_illegal_op%0d: got %h tag %0d (seen %b) want %h tag 10", i, rd, rt, ok, pat);
      end
    end
    send_one(3'd0, 64'h1, 6'd63, 4'h7, 1'b0, rd, rt, ok);
    n_vec++;
    if (!ok || rd !== 64'h8000_0000_0000_0000) begin
      n_err++;
      $display("FAIL bnd_sll63: got %h (seen %b) want 8000000000000000", rd, ok);
    end
    send_one(3'd2, 64'h4000_0000_0000_0000, 6'd62, 4'h3, 1'b0, rd, rt, ok);
    n_vec++;
    if (!ok || rd !== 64'h1) begin n_err++; $display("FAIL bnd_sra_pos: got %h (seen %b) want 1", rd, ok); end
    send_one(3'd3, 64'h8000_0000_0000_0001, 6'd1, 4'h4, 1'b0, rd, rt, ok);
    n_vec++;
    if (!ok || rd !== 64'h3) begin n_err++; $display("FAIL bnd_rol1: got %h (seen %b) want 3", rd, ok); end
    send_one(3'd4, 64'h1, 6'd63, 4'h5, 1'b0, rd, rt, ok);
    n_vec++;
    if (!ok || rd !== 64'h2) begin n_err++; $display("FAIL bnd_ror63: got %h (seen %b) want 2", rd, ok); end
  endtask

`ifdef SHIFT_WORD_OP_EN
  task automatic test_word();
    logic [W-1:0]  rd;
    logic [TW-1:0] rt;
    logic          ok;
    send_one(3'd1, 64'hFFFF_FFFF_8000_0000, 6'd31, 4'h1, 1'b1, rd, rt, ok);
    n_vec++;
    if (!ok || rd !== 64'h1) begin n_err++; $display("FAIL word_srl: got %h (seen %b) want 1", rd, ok); end
    send_one(3'd2, 64'hFFFF_FFFF_8000_0000, 6'd31, 4'h2, 1'b1, rd, rt, ok);
    n_vec++;
    if (!ok || rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_err++;
      $display("FAIL word_sra: got %h (seen %b) want ffffffffffffffff", rd, ok);
    end
    send_one(3'd0, 64'h1, 6'd63, 4'h3, 1'b1, rd, rt, ok);
    n_vec++;
    if (!ok || rd !== 64'hFFFF_FFFF_8000_0000) begin
      n_err++;
      $display("FAIL word_sll: got %h (seen %b) want ffffffff80000000", rd, ok);
    end
    send_one(3'd3, 64'h0000_0000_8000_0001, 6'd1, 4'h4, 1'b1, rd, rt, ok);
    n_vec++;
    if (!ok || rd !== 64'h3) begin n_err++; $display("FAIL word_rol: got %h (seen %b) want 3", rd, ok); end
  endtask
`endif

  // Random traffic with random backpressure against the scoreboard queue.
  task automatic test_random();
    logic [TW+W-1:0] exp;
    logic [2:0]      op;
    logic            w;
    exp_q.delete();
    for (int c = 0; c < 420; c++) begin
      if (c < 400 && $urandom_range(0, 9) < 7) begin
        op = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
`ifdef SHIFT_WORD_OP_EN
        w = 1'($urandom_range(0, 1));
`else
        w = 1'b0;
`endif
        drive_req(op, {$urandom, $urandom}, AW'($urandom_range(0, 63)), TW'($urandom_range(0, 15)), w);
      end else begin
        idle();
      end
      out_ready = (c >= 400) || ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rand_extra: unexpected result %h tag %0d", out_data, out_tag);
        end else begin
          exp = exp_q.pop_front();
          if ({out_tag, out_data} !== exp) begin
            n_err++;
            $display("FAIL rand_result: got %h tag %0d want %h tag %0d",
                     out_data, out_tag, exp[W-1:0], exp[TW+W-1:W]);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_tag, ref_shift(in_op, in_data, int'(in_amt), in_word)});
      end
      tick();
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_drain: %0d results missing want 0", exp_q.size()); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = '0;
    in_tag    = '0;
    in_word   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_boundaries();
`ifdef SHIFT_WORD_OP_EN
    test_word();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_shifter.md
Name: pipe_shifter

Overview:
Parametrised, pipelined barrel shifter for the ALU execute path. It generalises the combinational right shifter to left/right, logical/arithmetic and rotate modes. Width and pipeline depth are configurable, and a valid/ready handshake with backpressure carries a pass-through tag. It sits between operand issue and ALU writeback, and is shared by the shift and rotate instructions.

Parameters:
WIDTH, 64, data width in bits; must be a power of two, ≥8.
STAGES, 2, pipeline register stages; 1 ≤ STAGES ≤ AMT_W.
TAG_W, 4, width of the pass-through tag.
AMT_W, $clog2(WIDTH), shift-amount width; derived, not overridable.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
in_valid  in  1  request valid.
in_ready  out  1  request accepted when in_valid && in_ready.
in_data  in  WIDTH  operand.
in_amt  in  AMT_W  shift amount; modulo WIDTH by construction.
in_op  in  3  operation code; values defined in shift_pkg.
in_tag  in  TAG_W  opaque tag, returned unchanged.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts when out_valid && out_ready.
out_data  out  WIDTH  result.
out_tag  out  TAG_W  tag of the result.

Behaviour:
- Operation codes:
  - SLL=0: zero fill from the LSB.
  - SRL=1: zero fill from the MSB.
  - SRA=2: fill with in_data[WIDTH-1].
  - ROL=3: bits leaving the MSB re-enter at the LSB.
  - ROR=4: bits leaving the LSB re-enter at the MSB.
  - Codes 5-7 are illegal: result = in_data unshifted, tag kept, no error signal.
- Datapath:
  - AMT_W mux levels; level i shifts by 2^i when amt[i]=1.
  - Stage s owns levels [s*AMT_W/STAGES, (s+1)*AMT_W/STAGES), integer division. The final stage owns the remainder.
  - Each stage register carries valid, partial data, remaining amt bits, op, sign bit and tag.
- Latency: exactly STAGES cycles from acceptance to out_valid when out_ready stays high. Throughput is one result per cycle.
- Handshake and pipeline advance:
  - stage k advances when it is empty or stage k+1 advances; the last stage advances when it is empty or out_ready=1.
  - in_ready = first stage advances. Combinational from out_ready through the stall chain; no combinational path from in_* to out_*.
  - out_valid/out_data/out_tag hold stable while out_valid && !out_ready.
  - Capacity is STAGES entries; no result is ever dropped or duplicated, and results leave in acceptance order.
- Simultaneous accept and emit on a full pipeline with out_ready=1: both occur, occupancy is unchanged.
- amt=0: output equals input for every op.
- Reset:
  - rst_n=0 at a clock edge clears all stage valid bits; in flight data is discarded.
  - out_valid=0, out_data=0, out_tag=0 from the next cycle.
  - in_ready=1 from the first cycle after release (it is also 1 during reset).
  - Data registers are also cleared to 0.

Optional Feature:
Macro SHIFT_WORD_OP_EN.
- Defined:
  - Adds port in_word (in, 1), pipelined alongside op.
  - When in_word=1, the operation acts on in_data[31:0] with the amount masked to amt[4:0]. SRA fills from bit 31; rotates wrap at 32 bits.
  - The 32-bit result is sign-extended from bit 31 to WIDTH (RV64 *W semantics).
  - Requires WIDTH=64; elaboration error otherwise.
- Undefined: no in_word port; all operations are full WIDTH.

Decomposition:
- shift_pkg holds:
  - the shift_op_t enum (SLL, SRL, SRA, ROL, ROR)
  - the op width constant SHIFT_OP_W=3
  - the function that computes the stage level range.
- Sub-module shift_stage: one pipeline slice parametrised by first/last level. It contains the mux levels and the valid/ready register. pipe_shifter instantiates STAGES copies in a generate loop.

Test Plan:
1. SRA in=0x8000000000000000 amt=63 tag=5, out_ready=1 -> out_data=0xFFFFFFFFFFFFFFFF, out_tag=5, out_valid exactly 2 cycles after accept.
2. Back-to-back SRL in=0x8000000000000000 amt=63, then ROR in=0x1 amt=1, then ROL in=0x8000000000000000 amt=4 -> 0x1, 0x8000000000000000, 0x8 on consecutive cycles, in order.
3. Backpressure: out_ready=0 with 4 offered requests -> exactly 2 accepted, then in_ready=0 and out_data held stable. Raise out_ready -> all 4 results emitted in order, none lost or repeated.
4. Reset mid-flight: 2 entries in flight, rst_n=0 for one edge -> out_valid=0 the next cycle, in_ready=1, no stale result after release.
5. Boundaries: amt=0 for each op on 0x123456789ABCDEF0 returns the input unchanged; op=6 returns the input unchanged; SLL 0x1 amt=63 -> 0x8000000000000000.
6. With SHIFT_WORD_OP_EN defined:
   - in_word=1 SRL in=0xFFFFFFFF80000000 amt=31 -> 0x1.
   - SRA with the same input -> 0xFFFFFFFFFFFFFFFF.
   - SLL in=0x1 amt=63 (masked to 31) -> 0xFFFFFFFF80000000.
